// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer: reset (0xFF), BAT/ID check, enable streaming (0xF4),
// with a per-wait timeout and a bounded number of whole-sequence restarts.
module ps2_mouse_init_ctrl #(
    parameter int unsigned TO_BITS   = 25,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tx_ready,
    input  logic       tx_done,
    output logic       tx_stb,
    output logic [7:0] tx_data,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       stream_en,
    output logic       init_err,
    output logic [1:0] retry_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_RST,
        S_TXW_RST,
        S_ACK_RST,
        S_WAIT_BAT,
        S_WAIT_ID,
        S_SEND_EN,
        S_TXW_EN,
        S_ACK_EN,
        S_STREAM,
        S_ERROR
    } state_t;

    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

    state_t             state_q, state_d;
    logic [TO_BITS-1:0] to_q, to_d;
    logic [1:0]         retry_q, retry_d;
    logic               stream_en_q, stream_en_d;
    logic               init_err_q, init_err_d;
    logic               is_wait, enter_wait, to_expired, fail;

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        fail       = 1'b0;
        is_wait    = state_q inside {S_TXW_RST, S_ACK_RST, S_WAIT_BAT, S_WAIT_ID, S_TXW_EN, S_ACK_EN};
        to_expired = is_wait && (to_q == '0);

        // A received byte is always evaluated before the timeout.
        case (state_q)
            S_IDLE, S_STREAM, S_ERROR: begin
                if (start) begin
                    state_d = S_SEND_RST;
                    retry_d = '0;
                end
            end
            S_SEND_RST: if (tx_ready) state_d = S_TXW_RST;
            S_SEND_EN:  if (tx_ready) state_d = S_TXW_EN;
            S_TXW_RST: begin
                if (tx_done)         state_d = S_ACK_RST;
                else if (to_expired) fail = 1'b1;
            end
            S_TXW_EN: begin
                if (tx_done)         state_d = S_ACK_EN;
                else if (to_expired) fail = 1'b1;
            end
            S_ACK_RST: begin
                if (rx_valid) begin
                    if (rx_data == 8'hFA)      state_d = S_WAIT_BAT;
                    else if (rx_data == 8'hFE) state_d = S_SEND_RST;
                    else                       fail = 1'b1;
                end else if (to_expired) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_BAT: begin
                if (rx_valid) begin
                    if (rx_data == 8'hAA) state_d = S_WAIT_ID;
                    else                  fail = 1'b1;
                end else if (to_expired) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_ID: begin
                if (rx_valid) begin
                    if (rx_data == 8'h00) state_d = S_SEND_EN;
                    else                  fail = 1'b1;
                end else if (to_expired) begin
                    fail = 1'b1;
                end
            end
            S_ACK_EN: begin
                if (rx_valid) begin
                    if (rx_data == 8'hFA)      state_d = S_STREAM;
                    else if (rx_data == 8'hFE) state_d = S_SEND_EN;
                    else                       fail = 1'b1;
                end else if (to_expired) begin
                    fail = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 2'd1;
                state_d = S_SEND_RST;
            end else begin
                state_d = S_ERROR;
            end
        end

        enter_wait = (state_d != state_q) &&
                     (state_d inside {S_TXW_RST, S_ACK_RST, S_WAIT_BAT, S_WAIT_ID, S_TXW_EN, S_ACK_EN});
        if (enter_wait)   to_d = '1;
        else if (is_wait) to_d = to_q - {{(TO_BITS-1){1'b0}}, 1'b1};
        else              to_d = to_q;

        stream_en_d = (state_d == S_STREAM);
        init_err_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            to_q        <= '1;
            retry_q     <= '0;
            stream_en_q <= 1'b0;
            init_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_q        <= to_d;
            retry_q     <= retry_d;
            stream_en_q <= stream_en_d;
            init_err_q  <= init_err_d;
        end
    end

    // Strobe/data/busy are state decodes; rst masks them so they read idle during reset.
    always_comb begin
        tx_stb  = 1'b0;
        tx_data = 8'h00;
        busy    = 1'b0;
        if (!rst) begin
            tx_stb = tx_ready && (state_q == S_SEND_RST || state_q == S_SEND_EN);
            if (state_q == S_SEND_RST || state_q == S_TXW_RST) tx_data = 8'hFF;
            else if (state_q == S_SEND_EN || state_q == S_TXW_EN) tx_data = 8'hF4;
            busy = !(state_q inside {S_IDLE, S_STREAM, S_ERROR});
        end
    end

    assign stream_en = stream_en_q;
    assign init_err  = init_err_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Bench for ps2_mouse_init_ctrl: acts as transmitter and mouse, predicting strobes and
// final status from a script of device replies walked through the init protocol rules.
module tb_ps2_mouse_init_ctrl;
    localparam int unsigned TO_BITS    = 8;
    localparam int unsigned MAX_RETRY  = 3;
    localparam int          SILENT     = -1;
    localparam int          WAIT_LIMIT = 1000;

    logic       clk = 1'b0;
    logic       rst, start, tx_ready, tx_done, rx_valid;
    logic [7:0] rx_data;
    logic       tx_stb, busy, stream_en, init_err;
    logic [7:0] tx_data;
    logic [1:0] retry_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] stb_log[$];
    int         script[$];
    logic [7:0] exp_stb[$];
    int         seg_len[$];
    int         exp_retry;
    bit         exp_stream, exp_error;
    int         m_stage;

    always #5 clk = ~clk;

    ps2_mouse_init_ctrl #(.TO_BITS(TO_BITS), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_ready(tx_ready), .tx_done(tx_done),
        .tx_stb(tx_stb), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .stream_en(stream_en), .init_err(init_err), .retry_cnt(retry_cnt)
    );

    always @(negedge clk) begin
        if (tx_stb === 1'b1) begin
            stb_log.push_back(tx_data);
            checks++;
            if (tx_ready !== 1'b1) begin
                errors++;
                $display("FAIL stb_ready: tx_stb=1 while tx_ready=%b, required 1", tx_ready);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1; step(); tx_done = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d; step(); rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    task automatic wait_strobe(input bit rand_ready);
        for (int n = 0; n <= WAIT_LIMIT; n++) begin
            tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (tx_stb === 1'b1) begin
                step();
                return;
            end
            step();
        end
        checks++; errors++;
        $display("FAIL strobe_wait: no tx_stb within %0d cycles, required one", WAIT_LIMIT);
    endtask

    // Protocol model: stages 0=ack to reset, 1=BAT, 2=ID, 3=ack to enable, 4=finished.
    task automatic compute_expect();
        bit bad;
        exp_stb.delete(); seg_len.delete();
        exp_retry = 0; exp_stream = 0; exp_error = 0; m_stage = 0;
        exp_stb.push_back(8'hFF); seg_len.push_back(0);
        foreach (script[i]) begin
            bad = 0;
            seg_len[seg_len.size()-1]++;
            case (m_stage)
                0: if (script[i] == 'hFA) m_stage = 1;
                   else if (script[i] == 'hFE) begin exp_stb.push_back(8'hFF); seg_len.push_back(0); end
                   else bad = 1;
                1: if (script[i] == 'hAA) m_stage = 2; else bad = 1;
                2: if (script[i] == 'h00) begin m_stage = 3; exp_stb.push_back(8'hF4); seg_len.push_back(0); end
                   else bad = 1;
                3: if (script[i] == 'hFA) begin m_stage = 4; exp_stream = 1; end
                   else if (script[i] == 'hFE) begin exp_stb.push_back(8'hF4); seg_len.push_back(0); end
                   else bad = 1;
                default: ;
            endcase
            if (bad) begin
                if (exp_retry < int'(MAX_RETRY)) begin
                    exp_retry++; m_stage = 0;
                    exp_stb.push_back(8'hFF); seg_len.push_back(0);
                end else begin
                    exp_error = 1; m_stage = 4;
                end
            end
        end
    endtask

    task automatic gen_script();
        int pick, r;
        script.delete();
        compute_expect();
        while (!exp_stream && !exp_error) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 80 || script.size() > 40) r = (m_stage == 1) ? 'hAA : (m_stage == 2) ? 'h00 : 'hFA;
            else if (pick < 88) r = 'hFE;
            else if (pick < 97) r = int'($urandom_range(0, 255));
            else                r = SILENT;
            script.push_back(r);
            compute_expect();
        end
    endtask

    // Plays transmitter and device for the current script, with stray start/rx pulses
    // in states where they must be ignored.
    task automatic drive_script();
        int idx = 0;
        int r;
        compute_expect();
        stb_log.delete();
        pulse_start();
        foreach (seg_len[s]) begin
            wait_strobe(1'b1);
            repeat ($urandom_range(0, 4)) begin
                rx_valid = ($urandom_range(0, 1) == 1); rx_data = 8'hFA;
                start = ($urandom_range(0, 3) == 0);
                step();
            end
            rx_valid = 1'b0; start = 1'b0;
            pulse_done();
            for (int j = 0; j < seg_len[s]; j++) begin
                r = script[idx]; idx++;
                if (r == SILENT) break;
                repeat ($urandom_range(0, 5)) begin
                    start = ($urandom_range(0, 3) == 0);
                    step();
                end
                start = 1'b0;
                send_rx(8'(r));
            end
        end
        for (int n = 0; n < WAIT_LIMIT && busy === 1'b1; n++) step();
        repeat (2) step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (tx_stb !== 1'b0 || tx_data !== 8'h00) begin errors++;
            $display("FAIL rst_tx: tx_stb=%b tx_data=%h, required 0/00", tx_stb, tx_data); end
        checks++; if ({busy, stream_en, init_err} !== 3'b000) begin errors++;
            $display("FAIL rst_flags: busy/stream_en/init_err=%b, required 000", {busy, stream_en, init_err}); end
        checks++; if (retry_cnt !== 2'd0) begin errors++;
            $display("FAIL rst_retry: retry_cnt=%0d, required 0", retry_cnt); end
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (20) step();
        checks++; if (busy !== 1'b0 || stb_log.size() != 0) begin errors++;
            $display("FAIL idle_hold: busy=%b strobes=%0d, required 0/0", busy, stb_log.size()); end
    endtask

    task automatic test_sequences();
        for (int t = 0; t < 15; t++) begin
            script.delete();
            case (t)
                0: begin script.push_back('hFA); script.push_back('hAA); script.push_back('h00); script.push_back('hFA); end
                1: begin script.push_back('hFE); script.push_back('hFA); script.push_back('hAA);
                         script.push_back('h00); script.push_back('hFA); end
                2: begin script.push_back('hFA); script.push_back('hFC); script.push_back('hFA);
                         script.push_back('hAA); script.push_back('h00); script.push_back('hFA); end
                default: gen_script();
            endcase
            drive_script();
            checks++;
            if (stb_log.size() != exp_stb.size()) begin errors++;
                $display("FAIL seq%0d_stb_count: got %0d strobes, required %0d", t, stb_log.size(), exp_stb.size());
            end else begin
                foreach (exp_stb[i]) begin
                    checks++;
                    if (stb_log[i] !== exp_stb[i]) begin errors++;
                        $display("FAIL seq%0d_stb_data[%0d]: got %h, required %h", t, i, stb_log[i], exp_stb[i]); end
                end
            end
            checks++; if (stream_en !== exp_stream) begin errors++;
                $display("FAIL seq%0d_stream_en: got %b, required %b", t, stream_en, exp_stream); end
            checks++; if (init_err !== exp_error) begin errors++;
                $display("FAIL seq%0d_init_err: got %b, required %b", t, init_err, exp_error); end
            checks++; if (busy !== 1'b0) begin errors++;
                $display("FAIL seq%0d_busy: got %b, required 0", t, busy); end
            checks++; if (retry_cnt !== 2'(exp_retry)) begin errors++;
                $display("FAIL seq%0d_retry: got %0d, required %0d", t, retry_cnt, exp_retry); end
            checks++; if (tx_data !== 8'h00 || tx_stb !== 1'b0) begin errors++;
                $display("FAIL seq%0d_tx_idle: tx_data=%h tx_stb=%b, required 00/0", t, tx_data, tx_stb); end
        end
    endtask

    task automatic test_silent();
        int cnt;
        stb_log.delete();
        tx_ready = 1'b1;
        pulse_start();
        wait_strobe(1'b0);
        for (int k = 0; k <= int'(MAX_RETRY); k++) begin
            pulse_done();
            cnt = 0;
            while (cnt < WAIT_LIMIT) begin
                @(negedge clk);
                if (tx_stb === 1'b1 || busy !== 1'b1) break;
                cnt++;
                step();
            end
            step();
            checks++; if (cnt < 255 || cnt > 256) begin errors++;
                $display("FAIL silent_timeout%0d: %0d cycles in ACK_RST, required 255..256", k, cnt); end
            if (k < int'(MAX_RETRY)) begin
                checks++; if (retry_cnt !== 2'(k + 1)) begin errors++;
                    $display("FAIL silent_retry%0d: got %0d, required %0d", k, retry_cnt, k + 1); end
            end
        end
        repeat (2) step();
        checks++; if (init_err !== 1'b1 || busy !== 1'b0 || stream_en !== 1'b0) begin errors++;
            $display("FAIL silent_end: init_err/busy/stream_en=%b%b%b, required 100", init_err, busy, stream_en); end
        checks++; if (retry_cnt !== 2'd3) begin errors++;
            $display("FAIL silent_retry_sat: got %0d, required 3", retry_cnt); end
        checks++; if (stb_log.size() != int'(MAX_RETRY) + 1) begin errors++;
            $display("FAIL silent_stb_count: got %0d, required %0d", stb_log.size(), MAX_RETRY + 1); end
    endtask

    task automatic test_backpressure_collision();
        stb_log.delete();
        tx_ready = 1'b0;
        pulse_start();
        repeat (50) step();
        checks++; if (stb_log.size() != 0 || busy !== 1'b1) begin errors++;
            $display("FAIL bp_hold: strobes=%0d busy=%b, required 0/1", stb_log.size(), busy); end
        tx_ready = 1'b1;
        repeat (6) step();
        checks++; if (stb_log.size() != 1 || stb_log[0] !== 8'hFF) begin errors++;
            $display("FAIL bp_single: strobes=%0d, required exactly one 0xFF", stb_log.size()); end
        pulse_done();
        repeat (255) step();
        send_rx(8'hFA);
        repeat (3) step();
        checks++; if (stb_log.size() != 1 || retry_cnt !== 2'd0 || busy !== 1'b1) begin errors++;
            $display("FAIL collision: strobes=%0d retry=%0d busy=%b, required 1/0/1", stb_log.size(), retry_cnt, busy); end
        send_rx(8'hAA);
        send_rx(8'h00);
        wait_strobe(1'b0);
        pulse_done();
        send_rx(8'hFA);
        repeat (2) step();
        checks++; if (stream_en !== 1'b1 || retry_cnt !== 2'd0 || stb_log.size() != 2 || stb_log[1] !== 8'hF4) begin
            errors++;
            $display("FAIL collision_end: stream_en=%b retry=%0d strobes=%0d, required 1/0/2", stream_en, retry_cnt, stb_log.size());
        end
    endtask

    task automatic test_mid_reset();
        int n;
        tx_ready = 1'b1;
        pulse_start();
        wait_strobe(1'b0); pulse_done(); send_rx(8'hFA); send_rx(8'hFC);
        wait_strobe(1'b0); pulse_done(); send_rx(8'hFA);
        repeat (3) step();
        checks++; if (retry_cnt !== 2'd1 || busy !== 1'b1) begin errors++;
            $display("FAIL mid_pre: retry=%0d busy=%b, required 1/1", retry_cnt, busy); end
        rst = 1'b1;
        step();
        checks++; if ({tx_stb, busy, stream_en, init_err} !== 4'b0000 || tx_data !== 8'h00 || retry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst: stb/busy/stream/err=%b data=%h retry=%0d, required 0000/00/0",
                     {tx_stb, busy, stream_en, init_err}, tx_data, retry_cnt);
        end
        rst = 1'b0;
        n = stb_log.size();
        repeat (20) step();
        checks++; if (busy !== 1'b0 || stb_log.size() != n || retry_cnt !== 2'd0) begin errors++;
            $display("FAIL mid_idle: busy=%b strobes=%0d retry=%0d, required 0/%0d/0", busy, stb_log.size(), retry_cnt, n); end
        pulse_start();
        wait_strobe(1'b0);
        checks++; if (stb_log.size() != n + 1 || stb_log[$] !== 8'hFF) begin errors++;
            $display("FAIL mid_restart: strobes=%0d, required %0d ending in 0xFF", stb_log.size(), n + 1); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0; tx_done = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00;
        test_reset();
        test_sequences();
        test_silent();
        test_backpressure_collision();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_mouse_init_ctrl.md
PS2_MOUSE_INIT_CTRL -- requirements
Module: ps2_mouse_init_ctrl

Interface
REQ-001 SHALL have parameter TO_BITS, default 25, timeout counter width; expiry after 2^TO_BITS-1 cycles, about 670 ms at 50 MHz.
REQ-002 SHALL have parameter MAX_RETRY, default 3, maximum restarts of the init sequence before the error state.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin or re-begin initialization.
REQ-006 SHALL have port tx_ready, input, 1, host transmitter idle and able to accept a byte.
REQ-007 SHALL have port tx_done, input, 1, single-cycle pulse when the transmitter has finished a byte.
REQ-008 SHALL have port tx_stb, output, 1, single-cycle write strobe to the transmitter.
REQ-009 SHALL have port tx_data, output, 8, command byte to the transmitter.
REQ-010 SHALL have port rx_valid, input, 1, single-cycle pulse marking a received device byte.
REQ-011 SHALL have port rx_data, input, 8, received device byte; valid only when rx_valid=1.
REQ-012 SHALL have port busy, output, 1, high while a sequence is in progress.
REQ-013 SHALL have port stream_en, output, 1, high in STREAM; gates downstream packet decoding.
REQ-014 SHALL have port init_err, output, 1, high in ERROR.
REQ-015 SHALL have port retry_cnt, output, 2, number of restarts taken in the current sequence.

Function
REQ-016 SHALL implement states IDLE, SEND_RST, TXW_RST, ACK_RST, WAIT_BAT, WAIT_ID, SEND_EN, TXW_EN, ACK_EN, STREAM, ERROR.
REQ-017 IDLE/STREAM/ERROR: start=1 -> SEND_RST with retry_cnt cleared to 0; start in any other state SHALL be ignored.
REQ-018 SEND_x: tx_data SHALL be 0xFF in SEND_RST/TXW_RST and 0xF4 in SEND_EN/TXW_EN, and 0x00 elsewhere.
REQ-019 SEND_x: tx_stb SHALL be asserted for exactly one cycle, the first cycle with tx_ready=1, then -> TXW_x next cycle; no strobe while tx_ready=0.
REQ-020 TXW_x: on tx_done -> ACK_x.
REQ-021 ACK_x: rx_valid with 0xFA advances (ACK_RST -> WAIT_BAT, ACK_EN -> STREAM).
REQ-022 ACK_x: rx_valid with 0xFE (resend) -> back to SEND_x of the same command without incrementing retry_cnt.
REQ-023 ACK_x: any other byte is a failure.
REQ-024 WAIT_BAT: rx 0xAA -> WAIT_ID; rx 0xFC or any other byte is a failure.
REQ-025 WAIT_ID: rx 0x00 -> SEND_EN; any other byte is a failure.
REQ-026 Timeout counter SHALL load all-ones on every entry into TXW_x, ACK_x, WAIT_BAT or WAIT_ID, then decrement by 1 per cycle.
REQ-027 The counter reaching 0 in a wait state SHALL be a failure; the counter SHALL hold while in SEND_x, IDLE, STREAM or ERROR.
REQ-028 Failure: if retry_cnt < MAX_RETRY -> retry_cnt+1 and go to SEND_RST, else -> ERROR with retry_cnt held.
REQ-029 retry_cnt SHALL saturate at MAX_RETRY and never wrap.
REQ-030 rx_valid and timeout expiry in the same cycle: the received byte SHALL take priority over the timeout.
REQ-031 rx_valid in IDLE, SEND_x, TXW_x, STREAM or ERROR SHALL be ignored with no state change.
REQ-032 busy SHALL be 1 in every state except IDLE, STREAM and ERROR.
REQ-033 stream_en and init_err SHALL be registered state decodes, changing in the cycle after the state transition.

Reset
REQ-034 rst=1 SHALL force IDLE from any state, including mid-transfer, and load the timeout counter with all-ones.
REQ-035 rst=1 SHALL drive retry_cnt=0, tx_stb=0, tx_data=0x00, busy=0, stream_en=0, init_err=0.
REQ-036 After rst deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-037 Nominal sequence: start; tx_ready=1; device answers FA, AA, 00, FA.
 - tx_stb pulses twice, with 0xFF then 0xF4.
 - stream_en=1 and busy=0; retry_cnt=0.
REQ-038 Resend: device returns FE to 0xFF, then FA, AA, 00, FA.
 - 0xFF is strobed twice and retry_cnt stays 0.
 - ends in STREAM.
REQ-039 Bad BAT: device returns FC after the first reset.
 - retry_cnt=1 and a new 0xFF strobe follows.
 - a clean second pass ends in STREAM with retry_cnt=1.
REQ-040 Silent device with TO_BITS=8: no rx_valid.
 - restart after 255 idle cycles in ACK_RST.
 - after MAX_RETRY restarts: init_err=1, busy=0, retry_cnt=3.
REQ-041 Backpressure and collision: tx_ready held 0 for 50 cycles in SEND_RST.
 - no tx_stb until tx_ready=1, then exactly one strobe.
 - rx_valid=1 with 0xFA in the same cycle as timeout expiry -> advances to WAIT_BAT.
REQ-042 Mid-operation reset: rst asserted in WAIT_BAT.
 - next cycle all outputs at their reset values.
 - start afterwards re-issues 0xFF.
